// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port GPR file with per-register busy scoreboard
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = $clog2(REG_NUM),
  parameter int NR      = 3,
  parameter int NW      = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NR*ADDR_W-1:0]   rd_addr,
  output logic [NR*DATA_W-1:0]   rd_data,
  output logic [NR-1:0]          rd_busy,
  input  logic [NW-1:0]          wr_en,
  input  logic [NW*ADDR_W-1:0]   wr_addr,
  input  logic [NW*DATA_W-1:0]   wr_data,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_addr,
  output logic [REG_NUM-1:0]     busy_vec
);

  logic [DATA_W-1:0]  rf_q [REG_NUM];
  logic [DATA_W-1:0]  rf_d [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic [REG_NUM-1:0] wr_hit;
  logic [REG_NUM-1:0] iss_hit;

  always_comb begin
    wr_hit  = '0;
    iss_hit = '0;
    for (int w = 0; w < NW; w++) begin
      if (wr_en[w]) wr_hit[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (iss_en) iss_hit[iss_addr] = 1'b1;
  end

  // Later ports overwrite earlier ones, so the highest port index wins a collision.
  always_comb begin
    rf_d = rf_q;
    for (int w = 0; w < NW; w++) begin
      if (wr_en[w]) rf_d[wr_addr[w*ADDR_W +: ADDR_W]] = wr_data[w*DATA_W +: DATA_W];
    end
    rf_d[0] = '0;
  end

  // A new producer supersedes a retiring one, so set dominates clear.
  always_comb begin
    busy_d    = (busy_q & ~wr_hit) | iss_hit;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_q   <= '{default: '0};
      busy_q <= '0;
    end else begin
      rf_q   <= rf_d;
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NR; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    always_comb begin
      rd_data[i*DATA_W +: DATA_W] = rf_q[ra];
      rd_busy[i]                  = busy_q[ra];
`ifdef RF_BYPASS_EN
      for (int w = 0; w < NW; w++) begin
        if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == ra) begin
          rd_data[i*DATA_W +: DATA_W] = wr_data[w*DATA_W +: DATA_W];
          rd_busy[i]                  = iss_hit[ra];
        end
      end
`endif
      if (ra == '0) begin
        rd_data[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]                  = 1'b0;
      end
    end
  end

endmodule
